// File: rtl/sparrow_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction
// at a time: data-first priority, a fetch starvation guard and a response timeout.
module sparrow_mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_gnt,
    output logic        o_imem_rvalid,
    output logic [31:0] o_imem_rdata,
    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_wr,
    input  logic [1:0]  i_dmem_byte_en,
    input  logic [31:0] i_dmem_wdata,
    output logic        o_dmem_gnt,
    output logic        o_dmem_rvalid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wr,
    output logic [1:0]  o_mem_byte_en,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_timeout_err
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX  = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
    typedef enum logic {OWN_IMEM, OWN_DMEM} owner_t;

    state_t        state, state_d;
    owner_t        owner, owner_d;
    logic [SW-1:0] streak, streak_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic          mem_req_d, mem_wr_d;
    logic [31:0]   mem_addr_d, mem_wdata_d;
    logic [1:0]    mem_byte_en_d;
    logic          arb, pick_dmem, timeout_hit, rsp_fire;

    // Fetch only overtakes a pending data request once data has won MAX_DATA_STREAK times in a row.
    assign pick_dmem   = i_dmem_req && !(i_imem_req && (streak == STREAK_MAX));
    assign timeout_hit = (TIMEOUT > 0) && (state == WAIT_RSP) && !i_mem_rvalid && (tcnt == TIMEOUT_MAX);
    assign rsp_fire    = (state == WAIT_RSP) && (i_mem_rvalid || timeout_hit);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d       = state;
        owner_d       = owner;
        streak_d      = streak;
        tcnt_d        = tcnt;
        mem_req_d     = o_mem_req;
        mem_addr_d    = o_mem_addr;
        mem_wr_d      = o_mem_wr;
        mem_byte_en_d = o_mem_byte_en;
        mem_wdata_d   = o_mem_wdata;
        arb           = 1'b0;

        case (state)
            IDLE: begin
                if (i_imem_req || i_dmem_req) begin
                    arb     = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    mem_req_d = 1'b0;
                    tcnt_d    = '0;
                    state_d   = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (i_mem_rvalid) begin
                    if (i_imem_req || i_dmem_req) begin
                        arb     = 1'b1;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end else if (TIMEOUT > 0) begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb) begin
            mem_req_d = 1'b1;
            if (pick_dmem) begin
                owner_d       = OWN_DMEM;
                mem_addr_d    = i_dmem_addr;
                mem_wr_d      = i_dmem_wr;
                mem_byte_en_d = i_dmem_byte_en;
                mem_wdata_d   = i_dmem_wdata;
                if (!i_imem_req)
                    streak_d = '0;
                else if (streak != STREAK_MAX)
                    streak_d = streak + 1'b1;
            end else begin
                owner_d       = OWN_IMEM;
                mem_addr_d    = i_imem_addr;
                mem_wr_d      = 1'b0;
                mem_byte_en_d = 2'b10;
                mem_wdata_d   = '0;
                streak_d      = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            owner         <= OWN_IMEM;
            streak        <= '0;
            tcnt          <= '0;
            o_mem_req     <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wr      <= 1'b0;
            o_mem_byte_en <= '0;
            o_mem_wdata   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state         <= state_d;
            owner         <= owner_d;
            streak        <= streak_d;
            tcnt          <= tcnt_d;
            o_mem_req     <= mem_req_d;
            o_mem_addr    <= mem_addr_d;
            o_mem_wr      <= mem_wr_d;
            o_mem_byte_en <= mem_byte_en_d;
            o_mem_wdata   <= mem_wdata_d;
        end
    end

    // Timeout responses carry zero data; only a real memory response forwards rdata.
    assign o_imem_gnt    = (state == REQ) && i_mem_gnt && (owner == OWN_IMEM);
    assign o_dmem_gnt    = (state == REQ) && i_mem_gnt && (owner == OWN_DMEM);
    assign o_imem_rvalid = rsp_fire && (owner == OWN_IMEM);
    assign o_dmem_rvalid = rsp_fire && (owner == OWN_DMEM);
    assign o_imem_rdata  = (o_imem_rvalid && i_mem_rvalid) ? i_mem_rdata : '0;
    assign o_dmem_rdata  = (o_dmem_rvalid && i_mem_rvalid) ? i_mem_rdata : '0;
    assign o_timeout_err = timeout_hit;

endmodule

// File: tb/tb_sparrow_mem_arbiter.sv
// Scoreboard bench for sparrow_mem_arbiter: directed requests with a behavioural memory,
// expected grants and responses queued at issue and compared by an independent monitor.
module tb_sparrow_mem_arbiter;

    typedef struct {
        logic        dmem;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  be;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct {
        logic        dmem;
        logic [31:0] rdata;
        logic        err;
    } rsp_exp_t;

    logic        i_clk, i_reset_n;
    logic        i_imem_req, o_imem_gnt, o_imem_rvalid;
    logic [31:0] i_imem_addr, o_imem_rdata;
    logic        i_dmem_req, i_dmem_wr, o_dmem_gnt, o_dmem_rvalid;
    logic [31:0] i_dmem_addr, i_dmem_wdata, o_dmem_rdata;
    logic [1:0]  i_dmem_byte_en;
    logic        o_mem_req, o_mem_wr, i_mem_gnt, i_mem_rvalid, o_timeout_err;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [1:0]  o_mem_byte_en;

    gnt_exp_t    gnt_q[$];
    rsp_exp_t    rsp_q[$];
    logic [31:0] mem_data_q[$];

    int checks = 0;
    int errors = 0;

    int gnt_delay = 0;
    int rsp_delay = 0;
    bit mute      = 1'b0;
    int stray_req = 0;
    int m_phase, m_gcnt, m_rcnt, m_stray_seen;

    sparrow_mem_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_imem_req(i_imem_req), .i_imem_addr(i_imem_addr),
        .o_imem_gnt(o_imem_gnt), .o_imem_rvalid(o_imem_rvalid), .o_imem_rdata(o_imem_rdata),
        .i_dmem_req(i_dmem_req), .i_dmem_addr(i_dmem_addr), .i_dmem_wr(i_dmem_wr),
        .i_dmem_byte_en(i_dmem_byte_en), .i_dmem_wdata(i_dmem_wdata),
        .o_dmem_gnt(o_dmem_gnt), .o_dmem_rvalid(o_dmem_rvalid), .o_dmem_rdata(o_dmem_rdata),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wr(o_mem_wr),
        .o_mem_byte_en(o_mem_byte_en), .o_mem_wdata(o_mem_wdata),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_timeout_err(o_timeout_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model: gnt after gnt_delay cycles of o_mem_req, rvalid rsp_delay cycles after gnt.
    initial begin
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        m_phase = 0; m_gcnt = 0; m_rcnt = 0; m_stray_seen = 0;
        forever begin
            @(posedge i_clk); #1;
            i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
            if (!i_reset_n) begin
                m_phase = 0; m_gcnt = 0;
            end else if (m_phase == 0) begin
                if (stray_req != m_stray_seen) begin
                    m_stray_seen++;
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = 32'hBAD0_BAD0;
                end else if (o_mem_req) begin
                    if (m_gcnt >= gnt_delay) begin
                        i_mem_gnt = 1'b1; m_phase = 1; m_rcnt = 0; m_gcnt = 0;
                    end else begin
                        m_gcnt++;
                    end
                end else begin
                    m_gcnt = 0;
                end
            end else begin
                if (mute) begin
                    m_phase = 0;
                end else if (m_rcnt >= rsp_delay) begin
                    i_mem_rvalid = 1'b1;
                    if (mem_data_q.size() != 0) i_mem_rdata = mem_data_q.pop_front();
                    m_phase = 0;
                end else begin
                    m_rcnt++;
                end
            end
        end
    end

    // Monitor: compares every grant and every response against the scoreboard queues.
    initial begin
        gnt_exp_t ge;
        rsp_exp_t re;
        forever begin
            @(negedge i_clk);
            if (i_reset_n) begin
                if (o_imem_gnt || o_dmem_gnt) begin
                    check("gnt_onehot", 32'(o_imem_gnt & o_dmem_gnt), 32'd0);
                    check("gnt_expected", 32'(gnt_q.size() != 0), 32'd1);
                    if (gnt_q.size() != 0) begin
                        ge = gnt_q.pop_front();
                        check("gnt_owner_dmem", 32'(o_dmem_gnt), 32'(ge.dmem));
                        check("gnt_mem_req", 32'(o_mem_req), 32'd1);
                        check("gnt_mem_addr", o_mem_addr, ge.addr);
                        check("gnt_mem_wr", 32'(o_mem_wr), 32'(ge.wr));
                        check("gnt_mem_byte_en", 32'(o_mem_byte_en), 32'(ge.be));
                        check("gnt_mem_wdata", o_mem_wdata, ge.wdata);
                    end
                end
                if (o_imem_rvalid || o_dmem_rvalid || o_timeout_err) begin
                    check("rsp_valid", 32'(o_imem_rvalid | o_dmem_rvalid), 32'd1);
                    check("rsp_onehot", 32'(o_imem_rvalid & o_dmem_rvalid), 32'd0);
                    check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                    if (rsp_q.size() != 0) begin
                        re = rsp_q.pop_front();
                        check("rsp_owner_dmem", 32'(o_dmem_rvalid), 32'(re.dmem));
                        check("rsp_rdata", re.dmem ? o_dmem_rdata : o_imem_rdata, re.rdata);
                        check("rsp_other_rdata", re.dmem ? o_imem_rdata : o_dmem_rdata, 32'd0);
                        check("rsp_timeout_err", 32'(o_timeout_err), 32'(re.err));
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({o_mem_req, o_mem_wr, o_mem_byte_en, o_imem_gnt, o_imem_rvalid,
                                   o_dmem_gnt, o_dmem_rvalid, o_timeout_err}), 32'd0);
        check({tag, "_addr"}, o_mem_addr, 32'd0);
        check({tag, "_wdata"}, o_mem_wdata, 32'd0);
        check({tag, "_rdata"}, o_imem_rdata | o_dmem_rdata, 32'd0);
    endtask

    task automatic wait_gnt(input bit dmem);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge i_clk);
            n++;
            seen = dmem ? o_dmem_gnt : o_imem_gnt;
        end
        check(dmem ? "dmem_gnt_wait" : "imem_gnt_wait", 32'(seen), 32'd1);
        @(posedge i_clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (rsp_q.size() != 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_rsp_q", rsp_q.size(), 32'd0);
        @(posedge i_clk); #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata);
        gnt_q.push_back('{1'b0, addr, 1'b0, 2'b10, 32'h0});
        rsp_q.push_back('{1'b0, rdata, 1'b0});
        mem_data_q.push_back(rdata);
        i_imem_req = 1'b1; i_imem_addr = addr;
        wait_gnt(1'b0);
        i_imem_req = 1'b0;
        drain();
    endtask

    task automatic data_xfer(input logic [31:0] addr, input logic wr, input logic [1:0] be,
                             input logic [31:0] wdata, input logic [31:0] rdata);
        gnt_q.push_back('{1'b1, addr, wr, be, wdata});
        rsp_q.push_back('{1'b1, rdata, 1'b0});
        mem_data_q.push_back(rdata);
        i_dmem_req = 1'b1; i_dmem_addr = addr; i_dmem_wr = wr;
        i_dmem_byte_en = be; i_dmem_wdata = wdata;
        wait_gnt(1'b1);
        i_dmem_req = 1'b0;
        drain();
    endtask

    // Both requesters held high; pat lists the expected winners, D = data, I = fetch.
    task automatic burst(input string pat);
        int n = 0;
        int seen = 0;
        for (int k = 0; k < pat.len(); k++) begin
            if (pat[k] == "D") begin
                gnt_q.push_back('{1'b1, 32'h0000_8000, 1'b0, 2'b00, 32'h5555_AAAA});
                rsp_q.push_back('{1'b1, 32'hA000_0000 + k, 1'b0});
            end else begin
                gnt_q.push_back('{1'b0, 32'h0000_0100, 1'b0, 2'b10, 32'h0});
                rsp_q.push_back('{1'b0, 32'hA000_0000 + k, 1'b0});
            end
            mem_data_q.push_back(32'hA000_0000 + k);
        end
        i_imem_addr = 32'h0000_0100;
        i_dmem_addr = 32'h0000_8000; i_dmem_wr = 1'b0;
        i_dmem_byte_en = 2'b00; i_dmem_wdata = 32'h5555_AAAA;
        i_imem_req = 1'b1; i_dmem_req = 1'b1;
        while (seen < pat.len() && n < 200) begin
            @(negedge i_clk);
            n++;
            if (o_imem_gnt || o_dmem_gnt) seen++;
        end
        check("burst_cycles", n, 32'(2 * pat.len()));
        @(posedge i_clk); #1;
        i_imem_req = 1'b0; i_dmem_req = 1'b0;
        drain();
    endtask

    initial begin
        int n;
        bit hit;
        i_reset_n = 1'b0;
        i_imem_req = 1'b0; i_imem_addr = '0;
        i_dmem_req = 1'b0; i_dmem_addr = '0; i_dmem_wr = 1'b0;
        i_dmem_byte_en = '0; i_dmem_wdata = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("rst_init");
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        // Single fetch with cycle-exact latency
        gnt_q.push_back('{1'b0, 32'h1000, 1'b0, 2'b10, 32'h0});
        rsp_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
        mem_data_q.push_back(32'hDEAD_BEEF);
        i_imem_req = 1'b1; i_imem_addr = 32'h1000;
        @(negedge i_clk);
        check("t1_req_c0", 32'(o_mem_req), 32'd0);
        @(negedge i_clk);
        check("t1_req_c1", 32'(o_mem_req), 32'd1);
        check("t1_gnt_c1", 32'(o_imem_gnt), 32'd1);
        @(posedge i_clk); #1;
        i_imem_req = 1'b0;
        @(negedge i_clk);
        check("t1_rvalid_c2", 32'(o_imem_rvalid), 32'd1);
        check("t1_rdata_c2", o_imem_rdata, 32'hDEAD_BEEF);
        check("t1_req_c2", 32'(o_mem_req), 32'd0);
        check("t1_dmem_quiet", 32'({o_dmem_gnt, o_dmem_rvalid}) | o_dmem_rdata, 32'd0);
        drain();

        // Store, then load
        data_xfer(32'h2004, 1'b1, 2'b01, 32'h1234_5678, 32'h0);
        data_xfer(32'h2008, 1'b0, 2'b10, 32'h0, 32'h0BAD_F00D);

        // Starvation guard under continuous contention
        burst("DDDDIDDDDI");

        // Delayed gnt: request and fields held, single gnt pulse
        gnt_delay = 5;
        gnt_q.push_back('{1'b1, 32'h3008, 1'b0, 2'b10, 32'h0});
        rsp_q.push_back('{1'b1, 32'h3333_0000, 1'b0});
        mem_data_q.push_back(32'h3333_0000);
        i_dmem_req = 1'b1; i_dmem_addr = 32'h3008; i_dmem_wr = 1'b0;
        i_dmem_byte_en = 2'b10; i_dmem_wdata = 32'h0;
        @(negedge i_clk);
        check("dly_req_c0", 32'(o_mem_req), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            check("dly_req_held", 32'(o_mem_req), 32'd1);
            check("dly_addr_held", o_mem_addr, 32'h3008);
            check("dly_gnt", 32'(o_dmem_gnt), 32'(i == 5));
        end
        @(posedge i_clk); #1;
        i_dmem_req = 1'b0;
        gnt_delay = 0;
        @(negedge i_clk);
        check("dly_gnt_pulse", 32'(o_dmem_gnt), 32'd0);
        check("dly_req_drop", 32'(o_mem_req), 32'd0);
        drain();

        // rvalid arriving on the timeout cycle wins over the timeout
        rsp_delay = 8;
        data_xfer(32'h3010, 1'b0, 2'b00, 32'h0, 32'h7171_7171);
        rsp_delay = 0;

        // Timeout abort, then a stray rvalid in IDLE
        mute = 1'b1;
        gnt_q.push_back('{1'b0, 32'h4000, 1'b0, 2'b10, 32'h0});
        rsp_q.push_back('{1'b0, 32'h0, 1'b1});
        i_imem_req = 1'b1; i_imem_addr = 32'h4000;
        wait_gnt(1'b0);
        i_imem_req = 1'b0;
        n = 0; hit = 1'b0;
        while (!hit && n < 50) begin
            @(negedge i_clk);
            n++;
            hit = o_timeout_err;
        end
        check("timeout_latency", n, 32'd9);
        @(negedge i_clk);
        check("timeout_pulse", 32'({o_timeout_err, o_imem_rvalid}), 32'd0);
        mute = 1'b0;
        stray_req++;
        @(negedge i_clk);
        check("stray_ignored", 32'({o_imem_rvalid, o_dmem_rvalid, o_timeout_err, o_mem_req}), 32'd0);
        @(posedge i_clk); #1;
        fetch(32'h4004, 32'h4444_0004);

        // Reset during WAIT_RSP abandons the transaction and clears the streak
        rsp_delay = 4;
        gnt_q.push_back('{1'b1, 32'h7000, 1'b1, 2'b11, 32'h7777_7777});
        i_imem_req = 1'b1; i_imem_addr = 32'h7100;
        i_dmem_req = 1'b1; i_dmem_addr = 32'h7000; i_dmem_wr = 1'b1;
        i_dmem_byte_en = 2'b11; i_dmem_wdata = 32'h7777_7777;
        wait_gnt(1'b1);
        i_dmem_req = 1'b0;
        @(negedge i_clk); #1;
        i_reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        i_imem_req = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("rst_held");
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        rsp_delay = 0;
        @(posedge i_clk); #1;
        burst("DDDDI");
        fetch(32'h6000, 32'hCAFE_F00D);

        check("end_gnt_q", gnt_q.size(), 32'd0);
        check("end_rsp_q", rsp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
